reflet_run_ctrl: RTL and testbench

- Synthesizable run controller for Reflet CPU test harnesses and on-board self-test.
- Sequences the CPU's active-low reset after a configurable hold, then gates `enable` in free-run or single-step mode.
- Counts executed cycles and `debug` pulses, and detects `quit` or a timeout.
- Reports pass/fail against an expected debug count. Sits between the harness top and `reflet_cpu`, driving the CPU's `reset` and `enable`.

---
 rtl/reflet_run_pkg.sv | 20 ++
 rtl/reflet_sat_counter.sv | 40 ++++
 rtl/reflet_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_reflet_run_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_run_pkg.sv
// Shared definitions for the Reflet run controller: FSM state encoding and
// default timing parameters.
package reflet_run_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } run_state_e;

   localparam int DEFAULT_RESET_DELAY = 50;
   localparam int DEFAULT_TIMEOUT     = 1000;

   // The hold counter counts RESET_DELAY-1 down to 0.
   function automatic int hold_width(input int delay);
      return (delay > 1) ? $clog2(delay) : 1;
   endfunction

endpackage

// File: rtl/reflet_sat_counter.sv
// Up-counter with synchronous clear and increment enable; optionally holds at
// all-ones instead of wrapping. Exposes its next value for same-cycle decisions.
module reflet_sat_counter #(
   parameter int   W        = 8,
   parameter logic SATURATE = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next
);

   logic [W-1:0] count_q, count_d;
   logic         at_max;

   assign at_max = &count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !(SATURATE && at_max)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/reflet_run_ctrl.sv
// Run controller for the Reflet CPU: holds the CPU in reset, then gates its
// enable in free-run or single-step mode until quit, timeout or abort.
module reflet_run_ctrl
   import reflet_run_pkg::*;
#(
   parameter int RESET_DELAY = DEFAULT_RESET_DELAY,
   parameter int TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int CYC_W       = 16,
   parameter int DBG_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             step_mode,
   input  logic             step,
   input  logic [DBG_W-1:0] expected_debug,
   input  logic             quit,
   input  logic             debug,
   output logic             cpu_reset,
   output logic             cpu_enable,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic             timed_out,
   output logic [CYC_W-1:0] cycle_count,
   output logic [DBG_W-1:0] debug_count
);

   localparam int               HOLD_W    = hold_width(RESET_DELAY);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_DELAY - 1);
   localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(TIMEOUT);

   run_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              cpu_enable_q, cpu_enable_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timed_out_q, timed_out_d;

   logic             launch, run_en, cyc_inc, dbg_inc, hit_timeout;
   logic [CYC_W-1:0] cyc_next;
   logic [DBG_W-1:0] dbg_next;

   // A cycle counts only when the CPU was actually enabled and no abort lands on it.
   always_comb begin
      launch      = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
      run_en      = (state_q == ST_RUN) && cpu_enable_q && !abort;
      cyc_inc     = run_en;
      dbg_inc     = run_en && debug;
      hit_timeout = cyc_inc && (cyc_next == CYC_LIMIT);
   end

   reflet_sat_counter #(.W(CYC_W), .SATURATE(1'b1)) u_cycle_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (launch),
      .inc        (cyc_inc),
      .count      (cycle_count),
      .count_next (cyc_next)
   );

   reflet_sat_counter #(.W(DBG_W), .SATURATE(1'b1)) u_debug_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (launch),
      .inc        (dbg_inc),
      .count      (debug_count),
      .count_next (dbg_next)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      pass_d      = pass_q;
      timed_out_d = timed_out_q;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d     = ST_HOLD;
                  hold_d      = HOLD_LOAD;
                  pass_d      = 1'b0;
                  timed_out_d = 1'b0;
               end
            end
            ST_HOLD: begin
               if (hold_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            ST_RUN: begin
               // quit takes priority over a timeout landing on the same cycle
               if (quit) begin
                  state_d     = ST_DONE;
                  pass_d      = (dbg_next == expected_debug);
                  timed_out_d = 1'b0;
               end else if (hit_timeout) begin
                  state_d     = ST_DONE;
                  pass_d      = 1'b0;
                  timed_out_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are derived from the next state so they are registered alongside it.
      cpu_reset_d  = (state_d == ST_RUN) || (state_d == ST_DONE);
      cpu_enable_d = (state_d == ST_RUN) && (!step_mode || step);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         hold_q       <= '0;
         cpu_reset_q  <= 1'b0;
         cpu_enable_q <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cpu_reset_q  <= cpu_reset_d;
         cpu_enable_q <= cpu_enable_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         timed_out_q  <= timed_out_d;
      end
   end

   assign cpu_reset  = cpu_reset_q;
   assign cpu_enable = cpu_enable_q;
   assign running    = (state_q == ST_RUN);
   assign done       = done_q;
   assign pass       = pass_q;
   assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_reflet_run_ctrl.sv
// Self-checking bench for reflet_run_ctrl: the bench plays the CPU from a
// per-enabled-cycle debug/quit plan and predicts each run's outcome from it.
`timescale 1ns/1ps
module tb_reflet_run_ctrl;

   localparam int RD    = 50;
   localparam int TO    = 1000;
   localparam int CYC_W = 16;
   localparam int DBG_W = 8;

   logic             clk = 1'b0;
   logic             reset, start, abort, step_mode, step, quit, debug;
   logic [DBG_W-1:0] expected_debug;
   logic             cpu_reset, cpu_enable, running, done, pass, timed_out;
   logic [CYC_W-1:0] cycle_count;
   logic [DBG_W-1:0] debug_count;

   int n_cmp = 0;
   int n_bad = 0;
   bit dbg_plan [1:2100];

   always #5 clk = ~clk;

   reflet_run_ctrl #(.RESET_DELAY(RD), .TIMEOUT(TO), .CYC_W(CYC_W), .DBG_W(DBG_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode),
      .step(step), .expected_debug(expected_debug), .quit(quit), .debug(debug),
      .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .running(running), .done(done),
      .pass(pass), .timed_out(timed_out), .cycle_count(cycle_count), .debug_count(debug_count)
   );

   // Debug pulses the CPU stub issues over its first n enabled cycles, saturated.
   function automatic int plan_debugs(input int n);
      int s = 0;
      for (int i = 1; i <= n; i++) s += int'(dbg_plan[i]);
      return (s > 255) ? 255 : s;
   endfunction

   task automatic clear_plan();
      for (int i = 1; i <= 2100; i++) dbg_plan[i] = 1'b0;
   endtask

   task automatic random_plan(input int pct);
      for (int i = 1; i <= 2100; i++) dbg_plan[i] = ($urandom_range(99) < pct);
   endtask

   task automatic wait_hold_end();
      int g = 0;
      while (cpu_reset !== 1'b1 && g < RD + 20) begin
         g++;
         @(negedge clk);
      end
   endtask

   // One full run: start, hold, run until DONE, then check outcome against the plan.
   task automatic do_run(input string name, input int gap, input bit rnd, input int quit_at,
                         input logic [DBG_W-1:0] exp_dbg);
      int hold, n_en, cyc, en_err, first_bad, m_cyc, m_dbg;
      bit m_to, m_ps, prev_step, exp_en, stepped;
      logic [CYC_W-1:0] cc_done;
      logic [DBG_W-1:0] dc_done;
      stepped = (gap != 0) || rnd;
      m_to  = !(quit_at >= 1 && quit_at <= TO);
      m_cyc = m_to ? TO : quit_at;
      m_dbg = plan_debugs(m_cyc);
      m_ps  = !m_to && (m_dbg == int'(exp_dbg));

      @(negedge clk);
      expected_debug = exp_dbg; step_mode = stepped; step = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (cycle_count !== '0 || debug_count !== '0 || done !== 1'b0 || pass !== 1'b0 || timed_out !== 1'b0) begin
         n_bad++;
         $display("FAIL %s clear: cyc=%0d dbg=%0d done=%b pass=%b to=%b, required all 0",
                  name, cycle_count, debug_count, done, pass, timed_out);
      end
      hold = 0;
      while (cpu_reset === 1'b0 && hold < RD + 20) begin
         hold++;
         debug = 1'($urandom_range(1));
         quit  = 1'($urandom_range(1));
         @(negedge clk);
      end
      n_cmp++;
      if (hold != RD) begin
         n_bad++;
         $display("FAIL %s hold_len: got %0d cycles, required %0d", name, hold, RD);
      end

      n_en = 0; cyc = 0; en_err = 0; first_bad = -1; prev_step = 1'b0;
      while (running === 1'b1 && cyc < TO + 300) begin
         exp_en = stepped ? prev_step : 1'b1;
         if (cpu_enable !== exp_en || cpu_reset !== 1'b1) begin
            en_err++;
            if (first_bad < 0) first_bad = cyc;
         end
         if (cpu_enable === 1'b1) begin
            n_en++;
            debug = dbg_plan[n_en];
            quit  = (n_en == quit_at);
         end else begin
            debug = 1'b0;
            quit  = 1'b0;
         end
         step  = rnd ? 1'($urandom_range(1)) : (gap != 0 && (cyc % gap) == gap - 1);
         start = rnd ? ($urandom_range(3) == 0) : 1'b0;
         prev_step = step;
         cyc++;
         @(negedge clk);
      end
      step = 1'b0; start = 1'b0;
      n_cmp++;
      if (en_err != 0) begin
         n_bad++;
         $display("FAIL %s enable_pattern: %0d bad cycles (first at run cycle %0d), required 0", name, en_err, first_bad);
      end
      n_cmp++;
      if (done !== 1'b1 || running !== 1'b0 || cpu_enable !== 1'b0 || cpu_reset !== 1'b1) begin
         n_bad++;
         $display("FAIL %s done_state: done=%b run=%b en=%b rst=%b, required 1 0 0 1",
                  name, done, running, cpu_enable, cpu_reset);
      end
      n_cmp++;
      if (pass !== m_ps || timed_out !== m_to) begin
         n_bad++;
         $display("FAIL %s verdict: pass=%b timed_out=%b, required %b %b", name, pass, timed_out, m_ps, m_to);
      end
      n_cmp++;
      if (cycle_count !== CYC_W'(m_cyc) || debug_count !== DBG_W'(m_dbg)) begin
         n_bad++;
         $display("FAIL %s counts: cyc=%0d dbg=%0d, required %0d %0d", name, cycle_count, debug_count, m_cyc, m_dbg);
      end
      cc_done = CYC_W'(m_cyc);
      dc_done = DBG_W'(m_dbg);
      for (int i = 0; i < 4; i++) begin
         debug = 1'($urandom_range(1));
         quit  = 1'($urandom_range(1));
         @(negedge clk);
      end
      debug = 1'b0; quit = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || cpu_enable !== 1'b0 || cycle_count !== cc_done || debug_count !== dc_done) begin
         n_bad++;
         $display("FAIL %s done_hold: done=%b en=%b cyc=%0d dbg=%0d, required 1 0 %0d %0d",
                  name, done, cpu_enable, cycle_count, debug_count, cc_done, dc_done);
      end
      $display("run %s: enabled=%0d cycles=%0d debug=%0d pass=%b timed_out=%b",
               name, n_en, cycle_count, debug_count, pass, timed_out);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
      quit = 1'b0; debug = 1'b0; expected_debug = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (cpu_reset !== 1'b0 || cpu_enable !== 1'b0 || running !== 1'b0 || done !== 1'b0 ||
          pass !== 1'b0 || timed_out !== 1'b0 || cycle_count !== '0 || debug_count !== '0) begin
         n_bad++;
         $display("FAIL reset_state: rst=%b en=%b run=%b done=%b pass=%b to=%b cyc=%0d dbg=%0d, required all 0",
                  cpu_reset, cpu_enable, running, done, pass, timed_out, cycle_count, debug_count);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (cpu_reset !== 1'b0 || running !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: rst=%b run=%b, required 0 0", cpu_reset, running);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_free_run();
      clear_plan();
      dbg_plan[7] = 1'b1;
      do_run("free_pass", 0, 1'b0, 20, 8'd1);
      do_run("free_fail", 0, 1'b0, 20, 8'd2);
   endtask

   task automatic test_timeout();
      random_plan(5);
      do_run("timeout", 0, 1'b0, 0, DBG_W'(plan_debugs(TO)));
   endtask

   task automatic test_step();
      clear_plan();
      dbg_plan[2] = 1'b1;
      do_run("step_gap5", 5, 1'b0, 3, 8'd1);
      do_run("step_back_to_back", 1, 1'b0, 6, 8'd1);
   endtask

   task automatic test_coincide();
      random_plan(10);
      do_run("quit_at_timeout", 0, 1'b0, TO, DBG_W'(plan_debugs(TO)));
   endtask

   task automatic test_saturate();
      for (int i = 1; i <= 2100; i++) dbg_plan[i] = 1'b1;
      do_run("debug_saturate", 0, 1'b0, 300, 8'd255);
   endtask

   task automatic test_abort();
      int hi;
      clear_plan();
      dbg_plan[7] = 1'b1;
      @(negedge clk);
      step_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_hold_end();
      repeat (10) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      n_cmp++;
      if (running !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b0 || cpu_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_idle: run=%b done=%b rst=%b en=%b, required 0 0 0 0", running, done, cpu_reset, cpu_enable);
      end
      n_cmp++;
      if (cycle_count !== 16'd10) begin
         n_bad++;
         $display("FAIL abort_keep_count: cyc=%0d, required 10", cycle_count);
      end
      hi = 0;
      for (int i = 0; i < RD + 10; i++) begin
         if (cpu_reset !== 1'b0 || running !== 1'b0) hi++;
         @(negedge clk);
      end
      n_cmp++;
      if (hi != 0) begin
         n_bad++;
         $display("FAIL abort_beats_start: %0d non-idle cycles, required 0", hi);
      end
      $display("abort: mid-run abort with simultaneous start checked");
      do_run("after_abort", 0, 1'b0, 20, 8'd1);
   endtask

   task automatic test_async_reset();
      int hi;
      clear_plan();
      dbg_plan[7] = 1'b1;
      @(negedge clk);
      step_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (cpu_reset !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL areset_hold: rst=%b run=%b done=%b, required 0 0 0", cpu_reset, running, done);
      end
      @(negedge clk);
      reset = 1'b1;
      hi = 0;
      for (int i = 0; i < RD + 10; i++) begin
         if (cpu_reset !== 1'b0) hi++;
         @(negedge clk);
      end
      n_cmp++;
      if (hi != 0) begin
         n_bad++;
         $display("FAIL areset_stays_idle: %0d cycles with cpu_reset high, required 0", hi);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_hold_end();
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (cpu_reset !== 1'b0 || cpu_enable !== 1'b0 || running !== 1'b0 || cycle_count !== '0) begin
         n_bad++;
         $display("FAIL areset_run: rst=%b en=%b run=%b cyc=%0d, required 0 0 0 0",
                  cpu_reset, cpu_enable, running, cycle_count);
      end
      @(negedge clk);
      reset = 1'b1;
      $display("async_reset: mid-hold and mid-run reset checked");
      do_run("after_areset", 0, 1'b0, 20, 8'd1);
   endtask

   task automatic test_random();
      int q, c, e, gap;
      bit rnd;
      for (int k = 0; k < 8; k++) begin
         random_plan(30);
         q   = $urandom_range(40, 1);
         rnd = (k % 2) == 1;
         gap = rnd ? 0 : $urandom_range(4, 0);
         c   = plan_debugs(q);
         e   = ($urandom_range(1) == 1) ? c : c + 1;
         do_run($sformatf("random%0d", k), gap, rnd, q, DBG_W'(e));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_free_run();
      test_timeout();
      test_step();
      test_coincide();
      test_saturate();
      test_abort();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
